// File: rtl/uart_tx_frame_engine.sv
// Multi-byte UART transmitter: sends bytes N-1 down to 0 of a latched block,
// with optional parity, 1-2 stop bits, inter-byte idle gap and abort.
module uart_tx_frame_engine #(
  parameter int CLOCKS_PER_BIT = 10,
  parameter int MAX_BYTES      = 14,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int GAP_BITS       = 0,
  localparam int LEN_W         = $clog2(MAX_BYTES + 1)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_txBegin,
  input  logic [MAX_BYTES*8-1:0] i_txData,
  input  logic [LEN_W-1:0]       i_txDataLength,
  input  logic                   i_abort,
  output logic                   o_txBusy,
  output logic                   o_txSerial,
  output logic                   o_txDone,
  output logic                   o_txAborted
);

  localparam int BC_W   = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int SC_MAX = (STOP_BITS > GAP_BITS) ? STOP_BITS : GAP_BITS;
  localparam int SC_W   = $clog2(SC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t                 state, stateNext;
  logic [BC_W-1:0]        bitCnt, bitCntNext;
  logic [2:0]             bitIdx, bitIdxNext;
  logic [SC_W-1:0]        stopCnt, stopCntNext;
  logic [LEN_W-1:0]       byteCnt, byteCntNext;
  logic [MAX_BYTES*8-1:0] dataReg;
  logic                   dataLoad;
  logic                   txSerial, serialNext;
  logic                   txBusy, busyNext;
  logic                   txDone, doneNext;
  logic                   txAborted, abortedNext;
  logic [LEN_W-1:0]       lenClamp;
  logic [7:0]             curByte;
  logic                   parityBit;
  logic                   bitEnd;

  assign lenClamp  = (i_txDataLength > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : i_txDataLength;
  assign parityBit = (PARITY == 1) ? ~(^curByte) : ^curByte;
  assign bitEnd    = (bitCnt == BC_W'(CLOCKS_PER_BIT - 1));

  // Byte in flight is byteCnt-1; byteCnt counts bytes still to finish.
  always_comb begin
    curByte = '0;
    for (int k = 0; k < MAX_BYTES; k++)
      if (LEN_W'(k + 1) == byteCnt) curByte = dataReg[8*k +: 8];
  end

  always_comb begin
    stateNext   = state;
    bitCntNext  = bitCnt;
    bitIdxNext  = bitIdx;
    stopCntNext = stopCnt;
    byteCntNext = byteCnt;
    serialNext  = txSerial;
    busyNext    = txBusy;
    doneNext    = 1'b0;
    abortedNext = 1'b0;
    dataLoad    = 1'b0;

    if (state == S_IDLE) begin
      serialNext = 1'b1;
      busyNext   = 1'b0;
      if (i_txBegin) begin
        if (lenClamp == '0) begin
          doneNext = 1'b1;
        end else begin
          stateNext   = S_START;
          serialNext  = 1'b0;
          busyNext    = 1'b1;
          bitCntNext  = '0;
          byteCntNext = lenClamp;
          dataLoad    = 1'b1;
        end
      end
    end else if (i_abort) begin
      // Abort wins over everything, including a natural finish this cycle.
      stateNext   = S_IDLE;
      serialNext  = 1'b1;
      busyNext    = 1'b0;
      abortedNext = 1'b1;
      bitCntNext  = '0;
      bitIdxNext  = '0;
      stopCntNext = '0;
      byteCntNext = '0;
    end else if (!bitEnd) begin
      bitCntNext = bitCnt + BC_W'(1);
    end else begin
      bitCntNext = '0;
      unique case (state)
        S_START: begin
          stateNext  = S_DATA;
          bitIdxNext = '0;
          serialNext = curByte[0];
        end
        S_DATA: begin
          if (bitIdx == 3'd7) begin
            if (PARITY != 0) begin
              stateNext  = S_PARITY;
              serialNext = parityBit;
            end else begin
              stateNext   = S_STOP;
              stopCntNext = '0;
              serialNext  = 1'b1;
            end
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            serialNext = curByte[bitIdx + 3'd1];
          end
        end
        S_PARITY: begin
          stateNext   = S_STOP;
          stopCntNext = '0;
          serialNext  = 1'b1;
        end
        S_STOP: begin
          if (stopCnt == SC_W'(STOP_BITS - 1)) begin
            if (byteCnt != '0) byteCntNext = byteCnt - LEN_W'(1);
            stopCntNext = '0;
            if (byteCnt > LEN_W'(1)) begin
              if (GAP_BITS > 0) begin
                stateNext  = S_GAP;
                serialNext = 1'b1;
              end else begin
                stateNext  = S_START;
                serialNext = 1'b0;
              end
            end else begin
              stateNext  = S_IDLE;
              serialNext = 1'b1;
              busyNext   = 1'b0;
              doneNext   = 1'b1;
            end
          end else begin
            stopCntNext = stopCnt + SC_W'(1);
          end
        end
        S_GAP: begin
          if (stopCnt == SC_W'(GAP_BITS - 1)) begin
            stateNext   = S_START;
            stopCntNext = '0;
            serialNext  = 1'b0;
          end else begin
            stopCntNext = stopCnt + SC_W'(1);
          end
        end
        default: stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= S_IDLE;
      bitCnt    <= '0;
      bitIdx    <= '0;
      stopCnt   <= '0;
      byteCnt   <= '0;
      dataReg   <= '0;
      txSerial  <= 1'b1;
      txBusy    <= 1'b0;
      txDone    <= 1'b0;
      txAborted <= 1'b0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      bitIdx    <= bitIdxNext;
      stopCnt   <= stopCntNext;
      byteCnt   <= byteCntNext;
      txSerial  <= serialNext;
      txBusy    <= busyNext;
      txDone    <= doneNext;
      txAborted <= abortedNext;
      if (dataLoad) dataReg <= i_txData;
    end
  end

  assign o_txBusy    = txBusy;
  assign o_txSerial  = txSerial;
  assign o_txDone    = txDone;
  assign o_txAborted = txAborted;

endmodule

// File: doc/uart_tx_frame_engine.md
# uart_tx_frame_engine

Parametrised multi-byte UART transmitter that serialises a length-qualified block of up to MAX_BYTES bytes in one request. It has its own bit serialiser with configurable parity, stop bits and inter-byte idle gap, and supports abort. It sits between the display/control logic and the FPGA TX pin, and is the successor to the fixed 14-byte string sender.

## Interface
- CLOCKS_PER_BIT, 10: clock cycles per bit period; must be ≥2.
- MAX_BYTES, 14: capacity of i_txData in bytes; must be ≥1.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- GAP_BITS, 0: idle bit periods inserted between consecutive bytes. None is inserted after the last byte.
- LEN_W (localparam): $clog2(MAX_BYTES+1).

Ports:
- i_clock, in, 1: single clock.
- i_reset, in, 1: synchronous reset, active-high.
- i_txBegin, in, 1: start request. Sampled only while o_txBusy=0.
- i_txData, in, MAX_BYTES*8: payload. Byte k occupies bits [8k+7:8k].
- i_txDataLength, in, LEN_W: number of bytes to send. Values above MAX_BYTES are clamped to MAX_BYTES.
- i_abort, in, 1: cancels the transfer in progress. Ignored when idle.
- o_txBusy, out, 1: a transfer is in progress.
- o_txSerial, out, 1: UART line; idles high.
- o_txDone, out, 1: one-cycle pulse on normal completion.
- o_txAborted, out, 1: one-cycle pulse on abort completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE, with i_txBegin=1:
  - Latch i_txData and the clamped length N.
  - If N=0, stay in IDLE, pulse o_txDone and leave o_txBusy=0.
  - Otherwise, set o_txBusy and enter START.
- Byte order: byte N-1 is sent first, then downwards to byte 0. Bits within a byte are sent LSB first.
- Frame per byte: start bit (0), 8 data bits, parity bit (only when PARITY≠0), then STOP_BITS stop bits (1). Each bit lasts exactly CLOCKS_PER_BIT cycles.
- Parity value:
  - Even mode: XOR of the 8 data bits.
  - Odd mode: the inverse of that XOR.
- After the last stop bit:
  - If bytes remain and GAP_BITS>0: go to GAP and hold the line at 1 for GAP_BITS*CLOCKS_PER_BIT cycles, then START.
  - If bytes remain and GAP_BITS=0: go directly to START.
  - If no bytes remain: go to IDLE.
- Counters: bit-period counter of width $clog2(CLOCKS_PER_BIT), bit index 0–7, stop/gap counter, and a byte counter of width LEN_W. The byte counter decrements after each frame's final stop bit; it never wraps below 0.
- i_txBegin while o_txBusy=1 is ignored and has no effect on the latched data.
- i_abort while o_txBusy=1, in any state:
  - Next edge: o_txSerial=1, o_txBusy=0, o_txAborted=1 for one cycle, state IDLE.
  - o_txDone is not asserted.
- i_abort and the natural final-bit completion in the same cycle: abort wins (o_txAborted=1, o_txDone=0).

## Timing
- Reset values (registered outputs, taking effect at the first edge with i_reset=1): o_txSerial=1, o_txBusy=0, o_txDone=0, o_txAborted=0. State returns to IDLE and all counters clear.
- Reset mid-frame truncates the frame; the line is high from the next edge onward.
- Begin acceptance: i_txBegin sampled at edge E0. From E0, o_txBusy=1 and o_txSerial=0 (first start bit). Latency from request to start bit is one cycle.
- Frame length F = (9 + (PARITY≠0) + STOP_BITS) * CLOCKS_PER_BIT cycles.
- o_txBusy remains high for exactly N*F + (N-1)*GAP_BITS*CLOCKS_PER_BIT cycles.
- At the following edge: o_txBusy=0 and o_txDone=1 for exactly one cycle.
- In the cycle where o_txDone=1, o_txBusy=0, so a new i_txBegin is accepted there. This gives back-to-back transfers with no idle bit.
- N=0: o_txDone=1 in the cycle after E0. o_txBusy and o_txSerial are unchanged.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

## Test plan
Unless stated otherwise: CLOCKS_PER_BIT=4, MAX_BYTES=4, PARITY=0, STOP_BITS=1, GAP_BITS=0.

1. Basic two-byte transfer. Stimulus: len=2, i_txData=0x0000_4142. Response: line sends 0x41 then 0x42; the first frame bit sequence is 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles. o_txBusy is high for 80 cycles, then o_txDone pulses once.
2. Even parity with two stop bits and gap. Configuration: PARITY=2, STOP_BITS=2, GAP_BITS=1. Stimulus: len=2, data 0x0707. Response: parity bit=1 in each frame; each frame is 48 cycles; a 4-cycle high gap separates the frames; busy lasts 100 cycles.
3. Zero length and clamping.
   - len=0: o_txDone pulses in the next cycle, o_txBusy stays 0, line stays 1.
   - len=7: exactly 4 bytes are sent, byte3 first.
4. Abort. Stimulus: i_abort asserted during the data bits of byte 2 of a 3-byte transfer. Response: next edge has line=1, busy=0, o_txAborted pulses, o_txDone is never asserted. A new begin in the following cycle starts cleanly.
5. Reset mid-frame. Stimulus: i_reset asserted mid-frame. Response: all outputs take their reset values at the next edge. Stimulus: i_txBegin pulsed mid-transfer with different data. Response: ignored; the original bytes complete unchanged.
6. Back-to-back transfer. Stimulus: i_txBegin asserted in the o_txDone cycle. Response: the start bit begins on the next edge, with no idle bit between transfers.
